// File: rtl/mmio_timer_if.sv
// CPU data-memory port as seen by the timer peripheral.
// Bus protocol: single-cycle and without a handshake. A transfer is the address
// presented in a cycle. It is a write when any dmem_wrstb lane is set and a
// read otherwise. Writes commit on the next posedge. Read data and sel are
// combinational in the same cycle. There is no valid/ready pair because the
// slave never stalls.
interface mmio_timer_if;
  logic [31:0] dmem_addr;
  logic [31:0] dmem_wrdata;
  logic [3:0]  dmem_wrstb;
  logic [31:0] dmem_rddata;
  logic        sel;

  modport master (
    output dmem_addr,
    output dmem_wrdata,
    output dmem_wrstb,
    input  dmem_rddata,
    input  sel
  );

  modport slave (
    input  dmem_addr,
    input  dmem_wrdata,
    input  dmem_wrstb,
    output dmem_rddata,
    output sel
  );
endinterface

// File: rtl/mmio_timer.sv
// Memory-mapped timer/compare peripheral.
// It contains a prescaled 32-bit up-counter, a compare match with optional
// auto-reload, sticky W1C status flags and a registered level interrupt.
module mmio_timer #(
  parameter logic [31:0] BASE_ADDR  = 32'hFFFF_0000,
  parameter int          PRESCALE_W = 8
) (
  input  logic         clk,
  input  logic         rst,
  mmio_timer_if.slave  bus,
  output logic         irq
);

  // Writable CTRL bits: EN, AUTO_RELOAD, IRQ_EN and the prescale field at [8 +: PRESCALE_W].
  localparam logic [31:0] CTRL_MASK =
    32'h0000_0007 | (((32'h1 << PRESCALE_W) - 32'h1) << 8);

  logic [31:0]           ctrl_q, ctrl_d;
  logic [31:0]           count_q, count_d;
  logic [31:0]           compare_q, compare_d;
  logic                  match_q, match_d;
  logic                  ovf_q, ovf_d;
  logic [PRESCALE_W-1:0] pre_cnt_q, pre_cnt_d;
  logic                  irq_q, irq_d;

  logic                  en, auto_reload, irq_en;
  logic [PRESCALE_W-1:0] prescale;
  logic                  tick, hit, match_set, ovf_set;
  logic                  wr_any, wr_ctrl, wr_count, wr_compare, wr_status;
  logic                  w1c_match, w1c_ovf;
  logic [1:0]            offset;
  logic [31:0]           lane_mask;
  logic                  unused_addr_lsb;

  // The two address LSBs are ignored. Word offsets only.
  assign unused_addr_lsb = &{1'b0, bus.dmem_addr[1:0]};

  assign en          = ctrl_q[0];
  assign auto_reload = ctrl_q[1];
  assign irq_en      = ctrl_q[2];
  assign prescale    = ctrl_q[8 +: PRESCALE_W];

  assign offset     = bus.dmem_addr[3:2];
  assign bus.sel    = (bus.dmem_addr[31:4] == BASE_ADDR[31:4]);
  assign wr_any     = bus.sel && (bus.dmem_wrstb != 4'b0000);
  assign wr_ctrl    = wr_any && (offset == 2'd0);
  assign wr_count   = wr_any && (offset == 2'd1);
  assign wr_compare = wr_any && (offset == 2'd2);
  assign wr_status  = wr_any && (offset == 2'd3);
  assign w1c_match  = wr_status && bus.dmem_wrstb[0] && bus.dmem_wrdata[0];
  assign w1c_ovf    = wr_status && bus.dmem_wrstb[0] && bus.dmem_wrdata[1];

  // Expand the byte strobes into a bit mask for the lane merge.
  always_comb begin
    lane_mask = 32'h0;
    for (int i = 0; i < 4; i++) begin
      lane_mask[8*i +: 8] = {8{bus.dmem_wrstb[i]}};
    end
  end

  function automatic logic [31:0] merge(input logic [31:0] old_v,
                                        input logic [31:0] new_v,
                                        input logic [31:0] mask);
    return (old_v & ~mask) | (new_v & mask);
  endfunction

  // Next-state logic for the prescaler, counter, compare, status and irq.
  always_comb begin
    ctrl_d    = ctrl_q;
    count_d   = count_q;
    compare_d = compare_q;
    pre_cnt_d = pre_cnt_q;
    match_set = 1'b0;
    ovf_set   = 1'b0;

    tick = en && (pre_cnt_q == prescale);
    hit  = (count_q == compare_q);

    // A write to CTRL restarts the prescale period. This also applies when the write leaves EN unchanged.
    if (wr_ctrl || !en || tick) begin
      pre_cnt_d = '0;
    end else begin
      pre_cnt_d = pre_cnt_q + PRESCALE_W'(1);
    end

    // The tick acts on the pre-write COUNT and COMPARE values.
    if (tick) begin
      if (hit) begin
        match_set = 1'b1;
      end
      if (hit && auto_reload) begin
        count_d = 32'h0;
      end else begin
        count_d = count_q + 32'd1;
        ovf_set = (count_q == 32'hFFFF_FFFF);
      end
    end

    // On a collision, the CPU write to COUNT overrides the tick result.
    if (wr_count) begin
      count_d = merge(count_q, bus.dmem_wrdata, lane_mask);
    end
    if (wr_compare) begin
      compare_d = merge(compare_q, bus.dmem_wrdata, lane_mask);
    end
    if (wr_ctrl) begin
      ctrl_d = merge(ctrl_q, bus.dmem_wrdata, lane_mask) & CTRL_MASK;
    end

    // When a set event and a W1C hit the same flag, the set event takes priority.
    match_d = (match_q & ~w1c_match) | match_set;
    ovf_d   = (ovf_q & ~w1c_ovf) | ovf_set;

    // irq follows the visible MATCH flag one cycle later.
    irq_d = irq_en & match_q;
  end

  // State registers. Reset has priority over writes and ticks.
  always_ff @(posedge clk) begin
    if (rst) begin
      ctrl_q    <= 32'h0;
      count_q   <= 32'h0;
      compare_q <= 32'hFFFF_FFFF;
      match_q   <= 1'b0;
      ovf_q     <= 1'b0;
      pre_cnt_q <= '0;
      irq_q     <= 1'b0;
    end else begin
      ctrl_q    <= ctrl_d;
      count_q   <= count_d;
      compare_q <= compare_d;
      match_q   <= match_d;
      ovf_q     <= ovf_d;
      pre_cnt_q <= pre_cnt_d;
      irq_q     <= irq_d;
    end
  end

  assign irq = irq_q;

  // Combinational read mux. It outputs zero when the window is not selected.
  always_comb begin
    bus.dmem_rddata = 32'h0;
    if (bus.sel) begin
      case (offset)
        2'd0:    bus.dmem_rddata = ctrl_q;
        2'd1:    bus.dmem_rddata = count_q;
        2'd2:    bus.dmem_rddata = compare_q;
        default: bus.dmem_rddata = {30'h0, ovf_q, match_q};
      endcase
    end
  end

endmodule

// File: tb/tb_mmio_timer.sv
// Directed testbench for mmio_timer. Expected values are computed by hand.
module tb_mmio_timer;

  localparam logic [31:0] BASE      = 32'hFFFF_0000;
  localparam logic [31:0] A_CTRL    = BASE + 32'h0;
  localparam logic [31:0] A_COUNT   = BASE + 32'h4;
  localparam logic [31:0] A_COMPARE = BASE + 32'h8;
  localparam logic [31:0] A_STATUS  = BASE + 32'hC;

  logic clk;
  logic rst;
  logic irq;

  mmio_timer_if bus ();

  mmio_timer #(.BASE_ADDR(BASE), .PRESCALE_W(8)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus),
    .irq (irq)
  );

  // Clock and reset
  initial clk = 1'b0;
  always #10 clk = ~clk;

  // Scoreboard state
  int          n_cmp = 0;
  int          n_err = 0;
  logic [31:0] exp_q[$];
  logic [31:0] rd_v;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    if (obs !== exp) begin
      n_err++;
      $display("FAIL %s: got %h expected %h", tag, obs, exp);
    end
  endtask

  // Driver tasks. They are called at a negedge. A write commits on the next posedge.
  task automatic bus_write(input logic [31:0] a, input logic [31:0] d, input logic [3:0] s);
    bus.dmem_addr   = a;
    bus.dmem_wrdata = d;
    bus.dmem_wrstb  = s;
    @(negedge clk);
    bus.dmem_wrstb  = 4'b0000;
  endtask

  task automatic bus_read(input logic [31:0] a, output logic [31:0] d);
    bus.dmem_addr  = a;
    bus.dmem_wrstb = 4'b0000;
    #1;
    d = bus.dmem_rddata;
  endtask

  task automatic check_reg(input string tag, input logic [31:0] a, input logic [31:0] exp);
    logic [31:0] v;
    bus_read(a, v);
    check(tag, v, exp);
  endtask

  task automatic wait_cycles(input int n);
    repeat (n) @(negedge clk);
  endtask

  initial begin
    rst             = 1'b1;
    bus.dmem_addr   = 32'h0;
    bus.dmem_wrdata = 32'h0;
    bus.dmem_wrstb  = 4'b0000;
    wait_cycles(2);
    rst = 1'b0;

    // 1. Reset state and readback
    exp_q.push_back(32'h0);
    exp_q.push_back(32'h0);
    exp_q.push_back(32'hFFFF_FFFF);
    exp_q.push_back(32'h0);
    for (int i = 0; i < 4; i++) begin
      bus_read(BASE + 32'(4 * i), rd_v);
      check($sformatf("rst_rd%0d", i), rd_v, exp_q.pop_front());
    end
    check("rst_irq", {31'h0, irq}, 32'h0);
    bus_read(BASE + 32'h10, rd_v);
    check("unsel_sel", {31'h0, bus.sel}, 32'h0);
    check("unsel_rd", rd_v, 32'h0);

    // 2. Prescaled count. PRESCALE=3 gives one tick every 4 cycles.
    bus_write(A_CTRL, 32'h0000_0301, 4'hF);
    wait_cycles(40);
    check_reg("presc_count", A_COUNT, 32'd10);
    bus_write(A_CTRL, 32'h0, 4'hF);
    wait_cycles(2);
    check_reg("presc_hold", A_COUNT, 32'd10);

    // 3. Compare with auto-reload, irq and W1C
    bus_write(A_COMPARE, 32'd5, 4'hF);
    bus_write(A_COUNT, 32'd3, 4'hF);
    bus_write(A_CTRL, 32'h0000_0007, 4'hF);
    wait_cycles(2);
    check_reg("ar_pre_count", A_COUNT, 32'd5);
    check_reg("ar_pre_status", A_STATUS, 32'h0);
    wait_cycles(1);
    check_reg("ar_count", A_COUNT, 32'd0);
    check_reg("ar_status", A_STATUS, 32'h1);
    check("ar_irq_lag", {31'h0, irq}, 32'h0);
    wait_cycles(1);
    check("ar_irq", {31'h0, irq}, 32'h1);
    bus_write(A_STATUS, 32'h1, 4'hF);
    check_reg("w1c_status", A_STATUS, 32'h0);
    check("w1c_irq_lag", {31'h0, irq}, 32'h1);
    wait_cycles(1);
    check("w1c_irq", {31'h0, irq}, 32'h0);
    bus_write(A_CTRL, 32'h0, 4'hF);
    check_reg("ar_stop_status", A_STATUS, 32'h0);

    // 4. Overflow
    bus_write(A_COUNT, 32'hFFFF_FFFE, 4'hF);
    bus_write(A_COMPARE, 32'h0, 4'hF);
    bus_write(A_STATUS, 32'h3, 4'hF);
    bus_write(A_CTRL, 32'h1, 4'hF);
    wait_cycles(2);
    check_reg("ovf_count", A_COUNT, 32'h0);
    check_reg("ovf_status", A_STATUS, 32'h2);
    wait_cycles(1);
    check_reg("ovf_m_count", A_COUNT, 32'h1);
    check_reg("ovf_m_status", A_STATUS, 32'h3);
    bus_write(A_CTRL, 32'h0, 4'hF);

    // 5. Collisions
    bus_write(A_CTRL, 32'h1, 4'hF);
    bus_write(A_COUNT, 32'h1234, 4'hF);
    check_reg("col_count", A_COUNT, 32'h1234);
    bus_write(A_CTRL, 32'h0, 4'hF);
    bus_write(A_STATUS, 32'h3, 4'hF);
    check_reg("col_clr", A_STATUS, 32'h0);
    bus_write(A_COMPARE, 32'h10, 4'hF);
    bus_write(A_COUNT, 32'hE, 4'hF);
    bus_write(A_CTRL, 32'h1, 4'hF);
    wait_cycles(2);
    bus_write(A_STATUS, 32'h1, 4'hF);
    check_reg("col_w1c_status", A_STATUS, 32'h1);
    check_reg("col_w1c_count", A_COUNT, 32'h11);
    bus_write(A_CTRL, 32'h0, 4'hF);

    // 6. Byte strobes, no-strobe access, CTRL mask and reset mid-operation
    bus_write(A_COMPARE, 32'hAABB_CCDD, 4'hF);
    bus_write(A_COMPARE, 32'h1122_3344, 4'b0101);
    check_reg("strb_compare", A_COMPARE, 32'hAA22_CC44);
    bus_write(A_COUNT, 32'hDEAD, 4'b0000);
    check_reg("nostrb_count", A_COUNT, 32'h12);
    bus_write(A_CTRL, 32'hFFFF_FFFF, 4'hF);
    check_reg("ctrl_mask", A_CTRL, 32'h0000_FF07);
    wait_cycles(1);
    check("run_irq", {31'h0, irq}, 32'h1);
    rst             = 1'b1;
    bus.dmem_addr   = A_COUNT;
    bus.dmem_wrdata = 32'h55;
    bus.dmem_wrstb  = 4'hF;
    @(negedge clk);
    bus.dmem_wrstb = 4'b0000;
    rst            = 1'b0;
    check("mid_rst_irq", {31'h0, irq}, 32'h0);
    check_reg("mid_rst_ctrl", A_CTRL, 32'h0);
    check_reg("mid_rst_count", A_COUNT, 32'h0);
    check_reg("mid_rst_compare", A_COMPARE, 32'hFFFF_FFFF);
    check_reg("mid_rst_status", A_STATUS, 32'h0);

    // Final report
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
